// File: rtl/bsg_rr_arb_one_hot_hold.sv
// bsg_rr_arb_one_hot_hold
// Registered round-robin arbiter. It turns a request vector into a one-hot
// grant and holds that grant until the consumer accepts it with yumi_i.
// The round-robin pointer moves only when a grant is accepted. grants_o is
// always all-zero or exactly one-hot, so it can drive a one-hot encoder
// directly.
//
// Optional build macro: BSG_RR_ARB_ONE_HOT_HOLD_ASSERT_EN
//   When defined, simulation-only protocol checks are compiled in.
//   When undefined, no checks are present and behaviour is unchanged.

module bsg_rr_arb_one_hot_hold #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o,
    output logic               v_o,
    input  logic               yumi_i
);

    // Pointer width; a single requester still gets a 1-bit pointer.
    localparam int LAST_W = (width_p == 1) ? 1 : $clog2(width_p);
    localparam logic [LAST_W-1:0] LAST_MAX = LAST_W'(width_p - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              r_state;
    logic [width_p-1:0]  r_grants;
    logic                r_v;
    logic [LAST_W-1:0]   r_last;

    logic [LAST_W-1:0]   w_grant_idx;
    logic [LAST_W-1:0]   w_ptr;
    logic [LAST_W-1:0]   w_start;
    logic [width_p-1:0]  w_pick;
    logic                w_accept;

    // A yumi only counts while a grant is actually held.
    assign w_accept = (r_state == GRANT) && yumi_i;

    // Binary index of the currently held one-hot grant.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < width_p; i++) begin
            if (r_grants[i]) begin
                w_grant_idx = LAST_W'(i);
            end
        end
    end

    // Pointer used by this cycle's pick: on acceptance the search restarts
    // just past the index being accepted, without waiting for r_last.
    always_comb begin
        w_ptr = w_accept ? w_grant_idx : r_last;
    end

    // Start index = (pointer + 1) mod width_p, with an explicit wrap so
    // non-power-of-two widths behave correctly.
    always_comb begin
        w_start = (w_ptr == LAST_MAX) ? '0 : (w_ptr + LAST_W'(1));
    end

    // Round-robin pick: search upward from w_start and take the first set
    // request, so the result is zero or one-hot.
    always_comb begin
        int  j_idx;
        logic found;
        w_pick = '0;
        found  = 1'b0;
        j_idx  = 0;
        for (int k = 0; k < width_p; k++) begin
            j_idx = int'(w_start) + k;
            if (j_idx >= width_p) begin
                j_idx = j_idx - width_p;
            end
            if (!found && reqs_i[j_idx]) begin
                w_pick[j_idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Arbitration FSM: registers grant, valid and pointer together.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state  <= IDLE;
            r_grants <= '0;
            r_v      <= 1'b0;
            r_last   <= LAST_MAX;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|reqs_i) begin
                        r_grants <= w_pick;
                        r_v      <= 1'b1;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (yumi_i) begin
                        r_last <= w_grant_idx;
                        if (|reqs_i) begin
                            // Back-to-back grant using the updated pointer.
                            r_grants <= w_pick;
                            r_v      <= 1'b1;
                            r_state  <= GRANT;
                        end else begin
                            r_grants <= '0;
                            r_v      <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_grants <= '0;
                    r_v      <= 1'b0;
                end
            endcase
        end
    end

    assign grants_o = r_grants;
    assign v_o      = r_v;

`ifdef BSG_RR_ARB_ONE_HOT_HOLD_ASSERT_EN
    logic [width_p-1:0] r_grants_prev;
    logic               r_v_prev;
    logic               r_yumi_prev;
    logic               r_prev_ok;

    // Remember the previous cycle's handshake to detect an unaccepted change.
    always_ff @(posedge clk_i) begin
        r_grants_prev <= grants_o;
        r_v_prev      <= v_o;
        r_yumi_prev   <= yumi_i;
        r_prev_ok     <= reset_n_i;
    end

    // Protocol checks, only while out of reset.
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            if (yumi_i && !v_o) begin
                $error("yumi_i asserted while v_o is low");
            end
            if ((grants_o & (grants_o - 1'b1)) != '0) begin
                $error("grants_o is not zero or one-hot: %b", grants_o);
            end
            if (r_prev_ok && r_v_prev && !r_yumi_prev
                && (grants_o != r_grants_prev)) begin
                $error("grants_o changed without acceptance: %b -> %b",
                       r_grants_prev, grants_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_rr_arb_one_hot_hold.sv
// Directed bench for bsg_rr_arb_one_hot_hold: a width 4 instance for the
// main handshake sequence and a width 5 instance for non-power-of-two wrap.

module tb_bsg_rr_arb_one_hot_hold;

    logic       clk;
    logic       rst4_n, rst5_n;
    logic [3:0] reqs4, grants4;
    logic [4:0] reqs5, grants5;
    logic       v4, v5, yumi4, yumi5;

    int errors = 0;
    int checks = 0;

    bsg_rr_arb_one_hot_hold #(.width_p(4)) dut4 (
        .clk_i(clk), .reset_n_i(rst4_n), .reqs_i(reqs4),
        .grants_o(grants4), .v_o(v4), .yumi_i(yumi4)
    );

    bsg_rr_arb_one_hot_hold #(.width_p(5)) dut5 (
        .clk_i(clk), .reset_n_i(rst5_n), .reqs_i(reqs5),
        .grants_o(grants5), .v_o(v5), .yumi_i(yumi5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
        $display("check %s observed=%b expected=%b", tag, got, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] g, input logic v);
        check({tag, ".grant"}, {4'b0, grants4}, {4'b0, g});
        check({tag, ".v"}, {7'b0, v4}, {7'b0, v});
    endtask

    initial begin
        logic [4:0] exp5;
        rst4_n = 1'b0; reqs4 = 4'b1111; yumi4 = 1'b0;
        rst5_n = 1'b0; reqs5 = 5'b11111; yumi5 = 1'b0;

        // Reset held with all requests set: nothing granted.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk4($sformatf("reset_hold%0d", c), 4'b0000, 1'b0);
        end

        // First grant after release goes to index 0.
        rst4_n = 1'b1;
        tick(); chk4("release", 4'b0001, 1'b1);

        // Rotation and wrap with yumi every cycle.
        yumi4 = 1'b1;
        tick(); chk4("rot1", 4'b0010, 1'b1);
        tick(); chk4("rot2", 4'b0100, 1'b1);
        tick(); chk4("rot3", 4'b1000, 1'b1);
        tick(); chk4("rot_wrap", 4'b0001, 1'b1);

        // Hold under back-pressure, including dropping the granted request.
        yumi4 = 1'b0; reqs4 = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            tick(); chk4($sformatf("hold%0d", c), 4'b0001, 1'b1);
        end
        reqs4 = 4'b0100;
        tick(); chk4("hold_drop", 4'b0001, 1'b1);
        yumi4 = 1'b1;
        tick(); chk4("hold_accept", 4'b0100, 1'b1);

        // Single requester at the top index, re-granted after wrap.
        reqs4 = 4'b1000;
        tick(); chk4("single_a", 4'b1000, 1'b1);
        tick(); chk4("single_b", 4'b1000, 1'b1);
        reqs4 = 4'b0000;
        tick(); chk4("to_idle", 4'b0000, 1'b0);

        // Yumi while idle is ignored: pointer stays at 3, so index 0 wins.
        tick(); chk4("idle_yumi", 4'b0000, 1'b0);
        yumi4 = 1'b0; reqs4 = 4'b1111;
        tick(); chk4("idle_ptr", 4'b0001, 1'b1);

        // Reset mid-grant drops the held grant; reset beats yumi.
        yumi4 = 1'b1; reqs4 = 4'b0100;
        tick(); chk4("pre_rst", 4'b0100, 1'b1);
        yumi4 = 1'b1; reqs4 = 4'b1111; rst4_n = 1'b0;
        tick(); chk4("mid_rst", 4'b0000, 1'b0);
        rst4_n = 1'b1; yumi4 = 1'b0;
        tick(); chk4("post_rst", 4'b0001, 1'b1);

        // Width 5: encoded index sequence 0,1,2,3,4,0 with valid every cycle.
        rst5_n = 1'b1; yumi5 = 1'b1;
        for (int a = 0; a < 6; a++) begin
            tick();
            exp5 = 5'b00001 << (a % 5);
            check($sformatf("w5_addr%0d.grant", a % 5),
                  {3'b0, grants5}, {3'b0, exp5});
            check($sformatf("w5_addr%0d.v", a % 5), {7'b0, v5}, 8'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
